// File: rtl/lcd_cls_command_responder.sv
// lcd_cls_command_responder: expands clear/line1/line2 strobes into PMOD CLS escape byte streams over a tx valid/ready handshake, with post-command gap holdoff; define LCD_CLS_SANITIZE_TEXT_EN to replace non-printable text chars with space
module lcd_cls_command_responder #(
  parameter int parm_gap_ce = 250
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_lcd_wr_clear_display,
  input  logic         i_lcd_wr_text_line1,
  input  logic         i_lcd_wr_text_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_lcd_command_ready,
  output logic [7:0]   o_tx_byte,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_cmd_done
);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
  typedef enum logic [1:0] {CMD_CLEAR, CMD_LINE1, CMD_LINE2} cmd_t;
  localparam logic [15:0] GAP_LAST = 16'(parm_gap_ce - 1);
  state_t       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  logic [4:0]   idx_q, idx_d;
  logic [15:0]  gap_q, gap_d;
  logic [127:0] text_q, text_d;
  logic         done_q, done_d;
  logic [3:0]   ci;
  logic [7:0]   chr, seq_byte;
  logic         last;
  function automatic logic [127:0] sanitize(input logic [127:0] t);
    logic [127:0] s;
    s = t;
`ifdef LCD_CLS_SANITIZE_TEXT_EN
    for (int i = 0; i < 16; i++)
      s[8*i +: 8] = (t[8*i +: 8] < 8'h20 || t[8*i +: 8] > 8'h7E) ? 8'h20 : t[8*i +: 8];
`endif
    return s;
  endfunction
  assign ci = 4'(idx_q - 5'd6);
  assign chr = text_q[{~ci, 3'b000} +: 8];
  assign seq_byte = idx_q == 5'd0 ? 8'h1B :
                    idx_q == 5'd1 ? 8'h5B :
                    idx_q == 5'd2 ? (cmd_q == CMD_CLEAR ? 8'h6A : cmd_q == CMD_LINE1 ? 8'h30 : 8'h31) :
                    idx_q == 5'd3 ? 8'h3B :
                    idx_q == 5'd4 ? 8'h30 :
                    idx_q == 5'd5 ? 8'h48 : chr;
  assign last = idx_q == (cmd_q == CMD_CLEAR ? 5'd2 : 5'd21);
  assign o_lcd_command_ready = state_q == ST_IDLE;
  assign o_tx_valid = state_q == ST_SEND;
  assign o_tx_byte = o_tx_valid ? seq_byte : 8'h00;
  assign o_cmd_done = done_q;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    idx_d = idx_q;
    gap_d = gap_q;
    text_d = text_q;
    done_d = done_q;
    if (i_ce_2_5mhz) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: if (i_lcd_wr_clear_display || i_lcd_wr_text_line1 || i_lcd_wr_text_line2) begin
          state_d = ST_SEND;
          idx_d = 5'd0;
          cmd_d = i_lcd_wr_clear_display ? CMD_CLEAR : i_lcd_wr_text_line1 ? CMD_LINE1 : CMD_LINE2;
          text_d = i_lcd_wr_clear_display ? text_q : sanitize(i_lcd_wr_text_line1 ? i_dat_ascii_line1 : i_dat_ascii_line2);
        end
        ST_SEND: if (i_tx_ready) begin
          if (last) begin
            done_d = 1'b1;
            gap_d = 16'd0;
            state_d = parm_gap_ce == 0 ? ST_IDLE : ST_GAP;
          end else idx_d = idx_q + 5'd1;
        end
        ST_GAP: begin
          state_d = gap_q == GAP_LAST ? ST_IDLE : ST_GAP;
          gap_d = &gap_q ? gap_q : gap_q + 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= ST_IDLE;
      cmd_q <= CMD_CLEAR;
      idx_q <= 5'd0;
      gap_q <= 16'd0;
      text_q <= 128'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      text_q <= text_d;
      done_q <= done_d;
    end
  end
endmodule
